// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// Holds the register-file geometry and the register-address type that both
// the destination-register mux and the register file agree on.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;   // hardwired-zero register
  localparam reg_addr_t REG_RA   = 5'd31;  // return-address register

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
// Ports:
//   addr      - read address
//   regs      - committed storage, entry i at regs[i]
//   we/waddr/wdata - the write port of the current cycle (bypass source)
//   bypass_en - 1: a same-cycle write to addr is forwarded to rdata
//   rdata     - read data; always 0 for address 0
module rf_read_port #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]                     addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    regs,
  input  logic                                  we,
  input  logic [ADDR_W-1:0]                     waddr,
  input  logic [DATA_W-1:0]                     wdata,
  input  logic                                  bypass_en,
  output logic [DATA_W-1:0]                     rdata
);

  always_comb begin
    rdata = '0;
    if (addr == '0) begin
      rdata = '0;
    end else if (bypass_en && we && (waddr == addr)) begin
      // Forwarding is deliberately not gated by reset: the write is shown
      // even in a cycle where it will not be committed.
      rdata = wdata;
    end else begin
      rdata = regs[addr];
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32-entry general-purpose register file.
// Ports:
//   clk, rst_n          - clock; synchronous active-low reset clears all entries
//   raddr1/rdata1       - operand read port 1 (combinational, optional bypass)
//   raddr2/rdata2       - operand read port 2 (combinational, optional bypass)
//   we/waddr/wdata      - writeback port, committed on the rising edge
//   dbg_addr/dbg_data   - debug read port, committed state only
// Register 0 reads as zero and ignores writes.
module reg_file #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int   DEPTH  = 2**ADDR_W;
  localparam logic BYP_EN = (BYPASS != 0);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .addr      (raddr1),
    .regs      (regs_q),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .bypass_en (BYP_EN),
    .rdata     (rdata1)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .addr      (raddr2),
    .regs      (regs_q),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .bypass_en (BYP_EN),
    .rdata     (rdata2)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg (
    .addr      (dbg_addr),
    .regs      (regs_q),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .bypass_en (1'b0),
    .rdata     (dbg_data)
  );

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry general-purpose register file for the CPU datapath.
- Sits directly downstream of the 5-bit destination-register select mux: that mux's 5-bit output drives this block's write address `waddr`.
- Provides two combinational read ports for the decode/execute operands, one synchronous write port for writeback, and one debug read port.
- Optional write-to-read bypass so a same-cycle write is visible to readers; the pipelined variant relies on this.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return stored contents only.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- raddr1  input  ADDR_W  read port 1 address (rs).
- rdata1  output  DATA_W  read port 1 data, combinational.
- raddr2  input  ADDR_W  read port 2 address (rt).
- rdata2  output  DATA_W  read port 2 data, combinational.
- we  input  1  write enable (RegWrite).
- waddr  input  ADDR_W  write address, driven by the upstream destination-register mux.
- wdata  input  DATA_W  write data from writeback.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  DATA_W  debug read data, combinational, never bypassed.

Behaviour:
- Storage: 32 x DATA_W flops, regs[0..31].
- Reset:
  - On a rising clk edge with rst_n=0, all 32 entries become 0.
  - Reset has priority over a write in the same cycle, so the write is dropped.
  - There is no asynchronous path: while rst_n=0, outputs still reflect the old contents until the edge.
- Write:
  - On a rising clk edge with rst_n=1, we=1 and waddr!=0, regs[waddr] <= wdata.
  - No other entry changes.
  - we=0 means no change.
- Register 0:
  - Hardwired zero; writes to it are silently ignored.
  - Any read of address 0 returns 0 on every port, with or without bypass or a pending write.
- Read (per port p in {1,2}):
  - rdata_p = 0 if raddr_p==0.
  - Otherwise, if BYPASS=1 and we=1 and waddr==raddr_p, rdata_p = wdata.
  - Otherwise rdata_p = regs[raddr_p].
  - Pure combinational; zero-cycle latency.
- Bypass condition is not qualified by rst_n: while rst_n=0 and we=1 the forwarded value is still shown, but it is not committed.
- Both read ports may address the same register simultaneously; each gets an identical result.
- Debug port:
  - dbg_data = regs[dbg_addr], with 0 for address 0.
  - Never bypassed, so it shows only committed state.
- Write latency: written value visible on all ports from the cycle after the edge.
  - With BYPASS=1 it is also visible on rdata1/rdata2 in the write cycle itself.
- Widths: no arithmetic; addresses are used at full ADDR_W with no truncation.
- Lint: no latches; every output is assigned on all paths.

Decomposition:
- Shared package cpu_pkg holds:
  - Constants DATA_W=32, REG_ADDR_W=5, REG_ZERO=5'd0, REG_RA=5'd31.
  - A register-address typedef reg_addr_t (logic [4:0]), also used by the destination-register mux.
- Sub-module rf_read_port:
  - Inputs: addr, the storage array, we, waddr, wdata, and a bypass enable.
  - Function: applies the zero-register and bypass rules.
  - Instanced three times: ports 1 and 2 with bypass enable = BYPASS; the debug port with bypass tied to 0.

Test Plan:
- Reset: preload regs[5]=32'h1234 → assert rst_n=0 for 1 edge → rdata1 with raddr1=5 reads 32'h0 next cycle; all 32 entries read 0 via dbg sweep.
- Basic write/read: we=1, waddr=8, wdata=32'hDEADBEEF, edge → next cycle raddr1=8 and raddr2=8 both return 32'hDEADBEEF; dbg_addr=8 matches.
- Zero register: we=1, waddr=0, wdata=32'hFFFFFFFF, edge → rdata1 with raddr1=0 returns 32'h0; no other entry changed (dbg sweep).
- Bypass:
  - Stimulus: regs[3]=32'h11; same cycle we=1, waddr=3, wdata=32'h22, raddr1=3.
  - Required: rdata1=32'h22 before the edge; dbg_data (dbg_addr=3)=32'h11 before the edge and 32'h22 after.
  - Repeat with BYPASS=0: rdata1=32'h11 before the edge.
- Reset vs write collision: rst_n=0, we=1, waddr=9, wdata=32'hA5A5A5A5, edge → regs[9]=0 after the edge.
- Random regression: 1000 cycles of random we/waddr/wdata/raddr against a reference model; every port matches every cycle.
